// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - shared constants, FSM state encoding and vector codes
// for the interrupt controller (package int_pkg).
package int_pkg;

  localparam int NUM_IRQ          = 4;
  localparam int PC_WIDTH_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PUSH = 3'd1,
    JUMP = 3'd2,
    POP  = 3'd3,
    RET  = 3'd4
  } state_t;

  localparam logic [1:0] VEC_IRQ0 = 2'd0;
  localparam logic [1:0] VEC_IRQ1 = 2'd1;
  localparam logic [1:0] VEC_IRQ2 = 2'd2;
  localparam logic [1:0] VEC_IRQ3 = 2'd3;

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [1:0] idx);
    return NUM_IRQ'(1) << idx;
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// rtl/interrupt_controller_if.sv - request/CPU-side and PC/stack-side signal bundle;
// slave = controller, master = CPU/request sources.
interface interrupt_controller_if
  import int_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEFAULT
);
  logic [NUM_IRQ-1:0]  irq;
  logic                mask_we;
  logic [NUM_IRQ-1:0]  mask_d;
  logic                fetch_ok;
  logic                reti;
  logic [PC_WIDTH-1:0] pc_actual;
  logic                push;
  logic [PC_WIDTH-1:0] push_data;
  logic                pop;
  logic                take_vec;
  logic [1:0]          vec_sel;
  logic                take_ret;
  logic [NUM_IRQ-1:0]  ack;
  logic [NUM_IRQ-1:0]  in_service;
  logic                busy;

  modport slave (
    input  irq, mask_we, mask_d, fetch_ok, reti, pc_actual,
    output push, push_data, pop, take_vec, vec_sel, take_ret, ack, in_service, busy
  );

  modport master (
    output irq, mask_we, mask_d, fetch_ok, reti, pc_actual,
    input  push, push_data, pop, take_vec, vec_sel, take_ret, ack, in_service, busy
  );
endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational 4-to-2 priority encoder, index 0 highest.
module irq_prio_enc
  import int_pkg::*;
(
  input  logic [NUM_IRQ-1:0] i_req,
  output logic [1:0]         o_idx,
  output logic               o_valid
);

  always_comb begin
    o_idx   = VEC_IRQ0;
    o_valid = |i_req;
    if (i_req[0])      o_idx = VEC_IRQ0;
    else if (i_req[1]) o_idx = VEC_IRQ1;
    else if (i_req[2]) o_idx = VEC_IRQ2;
    else if (i_req[3]) o_idx = VEC_IRQ3;
  end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - ISR entry/return sequencer with fixed-priority arbitration.
// Define INT_NESTING_EN to let higher-priority sources preempt an active ISR.
module interrupt_controller
  import int_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEFAULT
) (
  input logic                    clk,
  input logic                    reset,
  interrupt_controller_if.slave  bus
);

  state_t              r_state;
  state_t              w_state_n;
  logic [NUM_IRQ-1:0]  r_irq_q;
  logic [NUM_IRQ-1:0]  r_pending;
  logic [NUM_IRQ-1:0]  r_mask;
  logic [NUM_IRQ-1:0]  r_in_service;
  logic [1:0]          r_win;
  logic [PC_WIDTH-1:0] r_push_data;

  logic [NUM_IRQ-1:0]  w_edge;
  logic [NUM_IRQ-1:0]  w_allow;
  logic [NUM_IRQ-1:0]  w_elig;
  logic [NUM_IRQ-1:0]  w_pend_clr;
  logic [1:0]          w_win_idx;
  logic                w_win_valid;
  logic [1:0]          w_svc_idx;
  logic                w_svc_valid;
  logic                w_go_push;
  logic                w_take_vec;
  logic                w_push;

  assign w_edge = bus.irq & ~r_irq_q;

  irq_prio_enc u_svc_enc (
    .i_req   (r_in_service),
    .o_idx   (w_svc_idx),
    .o_valid (w_svc_valid)
  );

`ifdef INT_NESTING_EN
  // Only sources strictly above the current service level may preempt.
  assign w_allow = w_svc_valid ? (onehot(w_svc_idx) - NUM_IRQ'(1)) : {NUM_IRQ{1'b1}};
`else
  assign w_allow = w_svc_valid ? {NUM_IRQ{1'b0}} : {NUM_IRQ{1'b1}};
`endif

  assign w_elig = r_pending & r_mask & w_allow;

  irq_prio_enc u_win_enc (
    .i_req   (w_elig),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  always_comb begin
    w_state_n = r_state;
    w_go_push = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.reti && w_svc_valid) begin
          w_state_n = POP;
        end else if (w_win_valid && bus.fetch_ok) begin
          w_state_n = PUSH;
          w_go_push = 1'b1;
        end
      end
      PUSH:    w_state_n = JUMP;
      JUMP:    w_state_n = IDLE;
      POP:     w_state_n = RET;
      RET:     w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // A fresh edge on the winner during JUMP re-arms its pending bit.
  assign w_pend_clr = (r_state == JUMP) ? onehot(r_win) : {NUM_IRQ{1'b0}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_irq_q      <= '0;
      r_pending    <= '0;
      r_mask       <= '0;
      r_in_service <= '0;
      r_win        <= VEC_IRQ0;
      r_push_data  <= '0;
    end else begin
      r_state   <= w_state_n;
      r_irq_q   <= bus.irq;
      r_pending <= (r_pending & ~w_pend_clr) | w_edge;
      if (bus.mask_we) begin
        r_mask <= bus.mask_d;
      end
      if (w_go_push) begin
        r_win       <= w_win_idx;
        r_push_data <= bus.pc_actual;
      end
      if (r_state == JUMP) begin
        r_in_service <= r_in_service | onehot(r_win);
      end else if (r_state == RET) begin
        r_in_service <= r_in_service & ~onehot(w_svc_idx);
      end
    end
  end

  assign w_push     = (r_state == PUSH);
  assign w_take_vec = (r_state == JUMP);

  assign bus.push       = w_push;
  assign bus.push_data  = w_push ? r_push_data : '0;
  assign bus.pop        = (r_state == POP);
  assign bus.take_vec   = w_take_vec;
  assign bus.vec_sel    = w_take_vec ? r_win : VEC_IRQ0;
  assign bus.take_ret   = (r_state == RET);
  assign bus.ack        = w_take_vec ? onehot(r_win) : {NUM_IRQ{1'b0}};
  assign bus.in_service = r_in_service;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - vector-table and scoreboard bench for interrupt_controller;
// expectations follow INT_NESTING_EN when it is defined.
module tb_interrupt_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  interrupt_controller_if #(.PC_WIDTH(10)) bus ();

  interrupt_controller #(.PC_WIDTH(10)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Packed view: {push, push_data, pop, take_vec, vec_sel, take_ret, ack, in_service, busy}
  typedef struct {
    logic [3:0]  irq;
    logic        mask_we;
    logic [3:0]  mask_d;
    logic        fetch_ok;
    logic        reti;
    logic [9:0]  pc;
    logic [24:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [24:0] sb[$];
  int          n_vec  = 0;
  int          n_miss = 0;

  function automatic logic [24:0] o(input logic ps, input logic [9:0] pd, input logic pp,
                                    input logic tv, input logic [1:0] vs, input logic tr,
                                    input logic [3:0] ak, input logic [3:0] is, input logic bz);
    return {ps, pd, pp, tv, vs, tr, ak, is, bz};
  endfunction

  function automatic logic [24:0] e_idle(input logic [3:0] is);
    return o(1'b0, 10'h0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, is, 1'b0);
  endfunction
  function automatic logic [24:0] e_push(input logic [9:0] pd, input logic [3:0] is);
    return o(1'b1, pd, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, is, 1'b1);
  endfunction
  function automatic logic [24:0] e_jump(input logic [1:0] vs, input logic [3:0] ak, input logic [3:0] is);
    return o(1'b0, 10'h0, 1'b0, 1'b1, vs, 1'b0, ak, is, 1'b1);
  endfunction
  function automatic logic [24:0] e_pop(input logic [3:0] is);
    return o(1'b0, 10'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0, is, 1'b1);
  endfunction
  function automatic logic [24:0] e_ret(input logic [3:0] is);
    return o(1'b0, 10'h0, 1'b0, 1'b0, 2'd0, 1'b1, 4'h0, is, 1'b1);
  endfunction

  function automatic logic [24:0] dut_out();
    return {bus.push, bus.push_data, bus.pop, bus.take_vec, bus.vec_sel, bus.take_ret,
            bus.ack, bus.in_service, bus.busy};
  endfunction

  task automatic add(input logic [3:0] irq, input logic we, input logic [3:0] md, input logic fok,
                     input logic reti, input logic [9:0] pc, input logic [24:0] e);
    vec_t v;
    v.irq = irq; v.mask_we = we; v.mask_d = md; v.fetch_ok = fok;
    v.reti = reti; v.pc = pc; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [24:0] exp);
    logic [24:0] got;
    got = dut_out();
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.irq = v.irq; bus.mask_we = v.mask_we; bus.mask_d = v.mask_d;
    bus.fetch_ok = v.fetch_ok; bus.reti = v.reti; bus.pc_actual = v.pc;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      sb.push_back(tbl[i].exp);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s_vec%0d", tag, i), sb.pop_front());
    end
    tbl.delete();
  endtask

  initial begin
    reset = 1'b1;
    bus.irq = 4'h0; bus.mask_we = 1'b0; bus.mask_d = 4'h0;
    bus.fetch_ok = 1'b0; bus.reti = 1'b0; bus.pc_actual = 10'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 25'd0);
    reset = 1'b0;

    // single irq[1] entry and return, then reti with nothing in service
    add(4'h0, 1, 4'hF, 1, 0, 10'h055, e_idle(4'h0));
    add(4'h2, 0, 4'h0, 1, 0, 10'h055, e_idle(4'h0));
    add(4'h2, 0, 4'h0, 1, 0, 10'h055, e_push(10'h055, 4'h0));
    add(4'h2, 0, 4'h0, 1, 0, 10'h055, e_jump(2'd1, 4'h2, 4'h0));
    add(4'h2, 0, 4'h0, 1, 0, 10'h055, e_idle(4'h2));
    add(4'h2, 0, 4'h0, 1, 1, 10'h055, e_pop(4'h2));
    add(4'h2, 0, 4'h0, 1, 0, 10'h055, e_ret(4'h2));
    add(4'h2, 0, 4'h0, 1, 0, 10'h055, e_idle(4'h0));
    add(4'h0, 0, 4'h0, 1, 1, 10'h055, e_idle(4'h0));
    add(4'h0, 0, 4'h0, 1, 0, 10'h055, e_idle(4'h0));
    // simultaneous irq[3] and irq[0]
    add(4'h9, 0, 4'h0, 1, 0, 10'h0AA, e_idle(4'h0));
    add(4'h9, 0, 4'h0, 1, 0, 10'h0AA, e_push(10'h0AA, 4'h0));
    add(4'h9, 0, 4'h0, 1, 0, 10'h0AA, e_jump(2'd0, 4'h1, 4'h0));
    add(4'h9, 0, 4'h0, 1, 0, 10'h0AA, e_idle(4'h1));
    add(4'h9, 0, 4'h0, 1, 1, 10'h0AA, e_pop(4'h1));
    add(4'h9, 0, 4'h0, 1, 0, 10'h0AA, e_ret(4'h1));
    add(4'h9, 0, 4'h0, 1, 0, 10'h0AA, e_idle(4'h0));
    add(4'h9, 0, 4'h0, 1, 0, 10'h0AA, e_push(10'h0AA, 4'h0));
    add(4'h9, 0, 4'h0, 1, 0, 10'h0AA, e_jump(2'd3, 4'h8, 4'h0));
    add(4'h9, 0, 4'h0, 1, 0, 10'h0AA, e_idle(4'h8));
    add(4'h9, 0, 4'h0, 1, 1, 10'h0AA, e_pop(4'h8));
    add(4'h9, 0, 4'h0, 1, 0, 10'h0AA, e_ret(4'h8));
    add(4'h9, 0, 4'h0, 1, 0, 10'h0AA, e_idle(4'h0));
    // masked irq[2] stays pending until the mask opens
    add(4'h9, 1, 4'hB, 1, 0, 10'h0AA, e_idle(4'h0));
    add(4'hD, 0, 4'h0, 1, 0, 10'h0AA, e_idle(4'h0));
    add(4'hD, 0, 4'h0, 1, 0, 10'h0AA, e_idle(4'h0));
    add(4'hD, 0, 4'h0, 1, 0, 10'h0AA, e_idle(4'h0));
    add(4'hD, 1, 4'hF, 1, 0, 10'h0AA, e_idle(4'h0));
    add(4'hD, 0, 4'h0, 1, 0, 10'h0AA, e_push(10'h0AA, 4'h0));
    add(4'hD, 0, 4'h0, 1, 0, 10'h0AA, e_jump(2'd2, 4'h4, 4'h0));
    add(4'hD, 0, 4'h0, 1, 0, 10'h0AA, e_idle(4'h4));
    // irq[0] edge while irq[2] is in service
    add(4'hC, 0, 4'h0, 1, 0, 10'h1F0, e_idle(4'h4));
    add(4'hD, 0, 4'h0, 1, 0, 10'h1F0, e_idle(4'h4));
`ifdef INT_NESTING_EN
    add(4'hD, 0, 4'h0, 1, 0, 10'h1F0, e_push(10'h1F0, 4'h4));
    add(4'hD, 0, 4'h0, 1, 0, 10'h1F0, e_jump(2'd0, 4'h1, 4'h4));
    add(4'hD, 0, 4'h0, 1, 0, 10'h1F0, e_idle(4'h5));
    add(4'hD, 0, 4'h0, 1, 1, 10'h1F0, e_pop(4'h5));
    add(4'hD, 0, 4'h0, 1, 0, 10'h1F0, e_ret(4'h5));
    add(4'hD, 0, 4'h0, 1, 0, 10'h1F0, e_idle(4'h4));
    add(4'hD, 0, 4'h0, 1, 1, 10'h1F0, e_pop(4'h4));
    add(4'hD, 0, 4'h0, 1, 0, 10'h1F0, e_ret(4'h4));
    add(4'hD, 0, 4'h0, 1, 0, 10'h1F0, e_idle(4'h0));
`else
    add(4'hD, 0, 4'h0, 1, 0, 10'h1F0, e_idle(4'h4));
    add(4'hD, 0, 4'h0, 1, 0, 10'h1F0, e_idle(4'h4));
    add(4'hD, 0, 4'h0, 1, 1, 10'h1F0, e_pop(4'h4));
    add(4'hD, 0, 4'h0, 1, 0, 10'h1F0, e_ret(4'h4));
    add(4'hD, 0, 4'h0, 1, 0, 10'h1F0, e_idle(4'h0));
    add(4'hD, 0, 4'h0, 1, 0, 10'h1F0, e_push(10'h1F0, 4'h0));
    add(4'hD, 0, 4'h0, 1, 0, 10'h1F0, e_jump(2'd0, 4'h1, 4'h0));
    add(4'hD, 0, 4'h0, 1, 0, 10'h1F0, e_idle(4'h1));
    add(4'hD, 0, 4'h0, 1, 1, 10'h1F0, e_pop(4'h1));
    add(4'hD, 0, 4'h0, 1, 0, 10'h1F0, e_ret(4'h1));
    add(4'hD, 0, 4'h0, 1, 0, 10'h1F0, e_idle(4'h0));
`endif
    // reti wins over a held-off eligible request in the same IDLE cycle
    add(4'h0, 0, 4'h0, 1, 0, 10'h123, e_idle(4'h0));
    add(4'h2, 0, 4'h0, 1, 0, 10'h123, e_idle(4'h0));
    add(4'h2, 0, 4'h0, 1, 0, 10'h123, e_push(10'h123, 4'h0));
    add(4'h2, 0, 4'h0, 1, 0, 10'h123, e_jump(2'd1, 4'h2, 4'h0));
    add(4'h3, 0, 4'h0, 0, 0, 10'h123, e_idle(4'h2));
    add(4'h3, 0, 4'h0, 0, 0, 10'h123, e_idle(4'h2));
    add(4'h3, 0, 4'h0, 1, 1, 10'h123, e_pop(4'h2));
    add(4'h3, 0, 4'h0, 1, 0, 10'h123, e_ret(4'h2));
    add(4'h3, 0, 4'h0, 1, 0, 10'h123, e_idle(4'h0));
    add(4'h3, 0, 4'h0, 1, 0, 10'h123, e_push(10'h123, 4'h0));
    add(4'h3, 0, 4'h0, 1, 0, 10'h123, e_jump(2'd0, 4'h1, 4'h0));
    add(4'h3, 0, 4'h0, 1, 0, 10'h123, e_idle(4'h1));
    add(4'h3, 0, 4'h0, 1, 1, 10'h123, e_pop(4'h1));
    add(4'h3, 0, 4'h0, 1, 0, 10'h123, e_ret(4'h1));
    add(4'h3, 0, 4'h0, 1, 0, 10'h123, e_idle(4'h0));
    // irq[2] edge, then into PUSH
    add(4'h7, 0, 4'h0, 1, 0, 10'h2A5, e_idle(4'h0));
    add(4'h7, 0, 4'h0, 1, 0, 10'h2A5, e_push(10'h2A5, 4'h0));
    run_table("main");

    // asynchronous reset in the middle of PUSH
    reset = 1'b1;
    #1;
    check("reset_mid_push", 25'd0);
    bus.irq = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold", 25'd0);
    reset = 1'b0;

    // pending was wiped: reopening the mask must not start an entry
    add(4'h0, 1, 4'hF, 1, 0, 10'h2A5, e_idle(4'h0));
    add(4'h0, 0, 4'h0, 1, 0, 10'h2A5, e_idle(4'h0));
    add(4'h0, 0, 4'h0, 1, 0, 10'h2A5, e_idle(4'h0));
    add(4'h0, 0, 4'h0, 1, 0, 10'h2A5, e_idle(4'h0));
    add(4'h0, 0, 4'h0, 1, 0, 10'h2A5, e_idle(4'h0));
    run_table("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Sequences entry into and return from interrupt service routines for the 8-bit CPU. Latches four interrupt request lines, e.g. timer `Clock_divider` outputs, into a masked pending set and arbitrates them by fixed priority. Drives the return-address stack (`pila` push/pop), the vector-select mux (`mux41` over `reg_int_1..4`) and the PC source select. Sits between the request sources and the PC/stack datapath.

## Interface
- `PC_WIDTH`, 10, width of PC and return address
- `NUM_IRQ`, 4, number of request lines (fixed at 4; vector select is 2 bits)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `irq`  in  4  request lines, rising-edge sensitive; `irq[0]` highest priority
- `mask_we`  in  1  load enable mask this cycle
- `mask_d`  in  4  new enable mask; 1 = enabled
- `fetch_ok`  in  1  CPU is at an instruction boundary; entry allowed
- `reti`  in  1  one-cycle pulse: CPU decoded return-from-interrupt
- `pc_actual`  in  PC_WIDTH  address of the next instruction (return address)
- `push`  out  1  one-cycle stack push strobe
- `push_data`  out  PC_WIDTH  address to push
- `pop`  out  1  one-cycle stack pop strobe
- `take_vec`  out  1  PC loads vector this cycle
- `vec_sel`  out  2  vector mux select; 00 = `irq[0]` … 11 = `irq[3]`
- `take_ret`  out  1  PC loads stack output this cycle
- `ack`  out  4  one-hot, one-cycle acknowledge to the accepted source
- `in_service`  out  4  sources currently in service
- `busy`  out  1  FSM not in IDLE

## Operation
- Edge detect: register `irq` into `irq_q`. When `irq & ~irq_q` is set, the matching `pending` bit is set next cycle. Repeated edges on a bit that is already pending are not counted.
- Eligible set = `pending & mask`, restricted to sources with priority strictly higher than the highest-priority `in_service` bit (nesting; see Configuration). Winner is the lowest set index.
- FSM states: IDLE, PUSH, JUMP, POP, RET.
- IDLE → POP: `reti` with `in_service` ≠ 0. This has priority over interrupt entry in the same cycle.
- IDLE → PUSH: eligible set ≠ 0 and `fetch_ok` = 1. Winner index is latched into `win`.
- PUSH: `push` = 1, `push_data` = `pc_actual` sampled on the IDLE→PUSH edge. Next state is JUMP.
- JUMP:
  - `take_vec` = 1, `vec_sel` = `win`, `ack[win]` = 1.
  - `pending[win]` clears and `in_service[win]` sets at end of cycle.
  - A new edge on `win` in the same cycle leaves `pending[win]` set.
  - Next state is IDLE.
- POP: `pop` = 1. Next state is RET.
- RET: `take_ret` = 1. The highest-priority `in_service` bit clears. Next state is IDLE.
- `reti` with `in_service` = 0 is ignored. `reti` outside IDLE is ignored; the CPU is stalled by `busy`.
- Mask write takes effect the next cycle. Masking never clears `pending`, and masked requests stay pending.
- Reset, asynchronous and valid at any state including mid-sequence:
  - state = IDLE.
  - `pending`, `in_service`, `mask`, `irq_q`, `win` = 0.
  - All strobes, `ack` and `busy` = 0; `vec_sel` = 00.

## Timing
- All outputs are decoded from registered state; no combinational path from inputs to outputs.
- Entry latency, from `irq` rising edge to `take_vec`: 4 cycles.
  - Cycle 1: edge registered.
  - Cycle 2: pending, FSM in IDLE.
  - Cycle 3: PUSH.
  - Cycle 4: JUMP.
  - Longer if `fetch_ok` = 0.
- Return latency, from `reti` to `take_ret`: 2 cycles (POP, RET).
- `push`/`pop` are never asserted in the same cycle. Each sequence produces exactly one strobe.

## Configuration
- `INT_NESTING_EN` defined:
  - A higher-priority source may preempt an active ISR, per the eligibility rule.
  - Maximum depth is 4, within the 8-entry stack.
- Undefined:
  - No entry while `in_service` ≠ 0; the eligible set is forced to 0 whenever any source is in service.
  - `in_service` has at most one bit set.

## Structure
- Shared package `int_pkg`: state encoding constants (IDLE/PUSH/JUMP/POP/RET), `NUM_IRQ`, `PC_WIDTH` default, and vector-select codes `VEC_IRQ0..VEC_IRQ3`.
- One sub-module: `irq_prio_enc`. Combinational 4→2 priority encoder with a `valid` output, index 0 highest. It is instantiated twice: once for the eligible set (winner) and once for the highest in-service bit (preemption level and RET clear).

## Test plan
- Reset mid-PUSH with `irq[2]` pending:
  - Required: all outputs 0, `pending` = 0 immediately on reset.
  - After release, no `push`.
- Mask = 1111, `pc_actual` = 10'h055, single `irq[1]` edge, `fetch_ok` = 1:
  - `push` with `push_data` = 10'h055 on cycle 3.
  - `take_vec`, `vec_sel` = 01, `ack` = 0010 on cycle 4.
  - `in_service` = 0010.
- Simultaneous edges on `irq[3]` and `irq[0]`, mask = 1111:
  - First entry uses `vec_sel` = 00.
  - After `reti` (POP, RET), second entry uses `vec_sel` = 11.
  - `irq[3]` stays pending throughout.
- Mask = 1011 with an `irq[2]` edge:
  - No entry, `pending[2]` = 1.
  - Write mask = 1111: entry with `vec_sel` = 10 within 3 cycles.
- In service on `irq[2]`, then an `irq[0]` edge:
  - With `INT_NESTING_EN`: preempts; `in_service` = 0101; two `reti` return in order.
  - Without it: no entry until `reti`.
- `reti` and an eligible request in the same IDLE cycle: POP occurs first. `reti` with `in_service` = 0: no `pop`.
